// File: rtl/multi_ch_event_sync.sv
`default_nettype none
// ============================================================================
//  Module      : multi_ch_event_sync
//  Description : Receive-side synchroniser for NUM_CH asynchronous level/toggle
//                inputs. Each channel is resynchronised, edge-detected and
//                counted in a saturating pending counter. Pending events are
//                offered to a single consumer in round-robin order over a
//                valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module multi_ch_event_sync #(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4,
   parameter int MODE        = 0,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] async_in,
   output logic [NUM_CH-1:0] evt_pulse,
   output logic              evt_valid,
   output logic [CH_W-1:0]   evt_chan,
   input  logic              evt_ready,
   output logic [NUM_CH-1:0] ovf_sticky,
   input  logic [NUM_CH-1:0] ovf_clr
);

   localparam int               ARM_W    = $clog2(SYNC_STAGES + 2);
   localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } state_t;

   logic [NUM_CH-1:0][SYNC_STAGES-1:0] sync_q;
   logic [NUM_CH-1:0]                  hist_q;
   logic [ARM_W-1:0]                   arm_q;
   logic [CNT_W-1:0]                   pend_q [NUM_CH];
   logic [CNT_W-1:0]                   pend_d [NUM_CH];
   logic [NUM_CH-1:0]                  ovf_q;
   logic [NUM_CH-1:0]                  ovf_d;
   logic [CH_W-1:0]                    rr_q;
   logic [CH_W-1:0]                    rr_d;
   logic [CH_W-1:0]                    chan_q;
   logic [CH_W-1:0]                    chan_d;
   state_t                             state_q;
   state_t                             state_d;

   logic [NUM_CH-1:0] w_sync_last;
   logic [NUM_CH-1:0] w_edge;
   logic              w_armed;
   logic              w_hs;
   logic [NUM_CH-1:0] w_dec;
   logic [NUM_CH-1:0] w_nz;
   logic [CH_W-1:0]   w_chan_next;
   logic [CH_W-1:0]   w_start;
   logic [CH_W-1:0]   w_pick;
   logic              w_found;

   // Resynchronise every channel and keep a one-cycle history of the last stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         hist_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], async_in[i]};
            hist_q[i] <= sync_q[i][SYNC_STAGES-1];
         end
      end
   end

   // Hold off detection until the chain and history hold real samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_q <= '0;
      end else if (arm_q != ARM_DONE) begin
         arm_q <= arm_q + 1'b1;
      end
   end

   assign w_armed = (arm_q == ARM_DONE);

   // Pick out the synchronised level of each channel
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         w_sync_last[i] = sync_q[i][SYNC_STAGES-1];
      end
   end

   generate
      if (MODE == 1) begin : g_rise
         assign w_edge = w_sync_last & ~hist_q;
      end else if (MODE == 2) begin : g_fall
         assign w_edge = ~w_sync_last & hist_q;
      end else begin : g_any
         assign w_edge = w_sync_last ^ hist_q;
      end
   endgenerate

   assign evt_pulse   = w_armed ? w_edge : '0;
   assign w_hs        = (state_q == ST_OFFER) && evt_ready;
   assign w_chan_next = (chan_q == CH_LAST) ? '0 : chan_q + 1'b1;

   // Saturating pending counters, overflow flags and post-handshake occupancy
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         w_dec[i]  = w_hs && (chan_q == CH_W'(i));
         pend_d[i] = pend_q[i];
         ovf_d[i]  = ovf_q[i] & ~ovf_clr[i];
         if (evt_pulse[i] && !w_dec[i]) begin
            if (pend_q[i] == CNT_MAX) begin
               ovf_d[i] = 1'b1;
            end else begin
               pend_d[i] = pend_q[i] + 1'b1;
            end
         end else if (!evt_pulse[i] && w_dec[i]) begin
            pend_d[i] = pend_q[i] - 1'b1;
         end
         // Occupancy as it stands once this cycle's grant is removed
         w_nz[i] = w_dec[i] ? (pend_q[i] > CNT_ONE) : (pend_q[i] != '0);
      end
   end

   // Register counters and overflow flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            pend_q[i] <= '0;
         end
         ovf_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            pend_q[i] <= pend_d[i];
         end
         ovf_q <= ovf_d;
      end
   end

   // Round-robin search: first occupied channel at or after the start point
   always_comb begin
      w_start = (state_q == ST_OFFER) ? w_chan_next : rr_q;
      w_found = 1'b0;
      w_pick  = '0;
      for (int off = 0; off < NUM_CH; off++) begin
         if (!w_found && w_nz[(int'(w_start) + off) % NUM_CH]) begin
            w_found = 1'b1;
            w_pick  = CH_W'((int'(w_start) + off) % NUM_CH);
         end
      end
   end

   // Offer FSM next-state: hold the offer until accepted, then chain without bubbles
   always_comb begin
      state_d = state_q;
      chan_d  = chan_q;
      rr_d    = rr_q;
      case (state_q)
         ST_IDLE: begin
            if (w_found) begin
               chan_d  = w_pick;
               state_d = ST_OFFER;
            end
         end
         ST_OFFER: begin
            if (w_hs) begin
               rr_d = w_chan_next;
               if (w_found) begin
                  chan_d = w_pick;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Offer FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         chan_q  <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         chan_q  <= chan_d;
         rr_q    <= rr_d;
      end
   end

   assign evt_valid  = (state_q == ST_OFFER);
   assign evt_chan   = chan_q;
   assign ovf_sticky = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_ch_event_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_ch_event_sync
//  Description : Directed self-checking bench for multi_ch_event_sync. Four
//                instances: default, CNT_W=2, rising-only and falling-only.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multi_ch_event_sync;

   logic       clk;
   logic       rst_n;
   logic [3:0] ain   [4];
   logic [3:0] pulse [4];
   logic [3:0] ovf   [4];
   logic [3:0] clr   [4];
   logic       valid [4];
   logic       ready [4];
   logic [1:0] chan  [4];

   int checks;
   int failures;
   int pc [4][4];
   int hs [4];
   int vc [4];
   int gnt [$];

   generate
      for (genvar g = 0; g < 4; g++) begin : g_dut
         multi_ch_event_sync #(
            .NUM_CH      (4),
            .SYNC_STAGES (2),
            .CNT_W       ((g == 1) ? 2 : 4),
            .MODE        ((g == 2) ? 1 : ((g == 3) ? 2 : 0))
         ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .async_in   (ain[g]),
            .evt_pulse  (pulse[g]),
            .evt_valid  (valid[g]),
            .evt_chan   (chan[g]),
            .evt_ready  (ready[g]),
            .ovf_sticky (ovf[g]),
            .ovf_clr    (clr[g])
         );
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // One clock: log handshakes seen before the edge, count pulses/valid after it
   task automatic tick();
      for (int d = 0; d < 4; d++) begin
         if (valid[d] && ready[d]) begin
            hs[d]++;
            if (d == 0) gnt.push_back(int'(chan[0]));
         end
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 4; c++) begin
            if (pulse[d][c]) pc[d][c]++;
         end
         if (valid[d]) vc[d]++;
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic clear_counts();
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 4; c++) pc[d][c] = 0;
         hs[d] = 0;
         vc[d] = 0;
      end
      gnt.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ticks(2);
      rst_n = 1'b1;
      ticks(6);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      for (int d = 0; d < 4; d++) begin
         ain[d]   = '0;
         clr[d]   = '0;
         ready[d] = 1'b0;
      end
      clear_counts();
      ticks(2);

      // Reset state
      chk("rst_valid", valid[0], 0);
      chk("rst_chan",  chan[0],  0);
      chk("rst_pulse", pulse[0], 0);
      chk("rst_ovf",   ovf[0],   0);
      rst_n = 1'b1;
      ticks(6);

      // 1: single rising event on channel 0, latency
      ain[0][0] = 1'b1;
      tick();
      chk("t1_pulse_e1", pulse[0][0], 0);
      tick();
      chk("t1_pulse_e2", pulse[0][0], 1);
      tick();
      chk("t1_pulse_e3", pulse[0][0], 0);
      chk("t1_valid_e3", valid[0], 0);
      tick();
      chk("t1_valid_e4", valid[0], 1);
      chk("t1_chan_e4",  chan[0],  0);
      ready[0] = 1'b1;
      tick();
      ready[0] = 1'b0;
      chk("t1_valid_after_hs", valid[0], 0);
      chk("t1_grants", gnt.size(), 1);

      // 2: three toggles on channel 2, then drain back-to-back
      clear_counts();
      for (int t = 0; t < 3; t++) begin
         ain[0][2] = ~ain[0][2];
         ticks(4);
      end
      chk("t2_pulses", pc[0][2], 3);
      chk("t2_valid",  valid[0], 1);
      chk("t2_chan",   chan[0],  2);
      gnt.delete();
      ready[0] = 1'b1;
      ticks(3);
      ready[0] = 1'b0;
      chk("t2_grants", gnt.size(), 3);
      for (int i = 0; i < 3; i++) chk("t2_grant_chan", gnt[i], 2);
      chk("t2_valid_end", valid[0], 0);

      // 3: round robin between channels 1 and 3, two events each
      clear_counts();
      do_reset();
      chk("t3_no_evt_held_level", pc[0][0] + pc[0][2], 0);
      ain[0] = ain[0] ^ 4'b1010;
      ticks(4);
      ain[0] = ain[0] ^ 4'b1010;
      ticks(4);
      chk("t3_valid", valid[0], 1);
      chk("t3_chan_first", chan[0], 1);
      ticks(3);
      chk("t3_chan_stable", chan[0], 1);
      gnt.delete();
      ready[0] = 1'b1;
      ticks(4);
      ready[0] = 1'b0;
      chk("t3_grants", gnt.size(), 4);
      chk("t3_g0", gnt[0], 1);
      chk("t3_g1", gnt[1], 3);
      chk("t3_g2", gnt[2], 1);
      chk("t3_g3", gnt[3], 3);
      chk("t3_valid_end", valid[0], 0);

      // 5: all-ones held through reset, then reset during an offer
      ain[0] = 4'hF;
      do_reset();
      clear_counts();
      ticks(10);
      chk("t5_held_pulses", pc[0][0] + pc[0][1] + pc[0][2] + pc[0][3], 0);
      chk("t5_held_valid",  vc[0], 0);
      ain[0][0] = 1'b0;
      ticks(4);
      chk("t5_offer_before_rst", valid[0], 1);
      rst_n = 1'b0;
      #2;
      chk("t5_async_rst_valid", valid[0], 0);
      ticks(2);
      rst_n = 1'b1;
      clear_counts();
      ticks(10);
      chk("t5_no_offer_after_rst", vc[0], 0);

      // 4: saturation and sticky overflow on the CNT_W=2 instance
      for (int e = 0; e < 4; e++) begin
         ain[1][0] = ~ain[1][0];
         ticks(3);
         if (e == 2) chk("t4_ovf_at_max", ovf[1][0], 0);
      end
      chk("t4_ovf_set", ovf[1][0], 1);
      ain[1][0] = ~ain[1][0];
      ticks(2);
      clr[1][0] = 1'b1;
      tick();
      clr[1][0] = 1'b0;
      chk("t4_set_wins", ovf[1][0], 1);
      clr[1][0] = 1'b1;
      tick();
      clr[1][0] = 1'b0;
      chk("t4_clr", ovf[1][0], 0);
      hs[1] = 0;
      ready[1] = 1'b1;
      ticks(6);
      ready[1] = 1'b0;
      chk("t4_drain_count", hs[1], 3);
      chk("t4_valid_end", valid[1], 0);

      // 6: square wave on channel 1, rising-only vs falling-only instances
      clear_counts();
      for (int i = 0; i < 3; i++) begin
         ain[2][1] = 1'b1;
         ain[3][1] = 1'b1;
         ticks(4);
         if (i < 2) begin
            ain[2][1] = 1'b0;
            ain[3][1] = 1'b0;
            ticks(4);
         end
      end
      ticks(2);
      chk("t6_rise_pulses", pc[2][1], 3);
      chk("t6_fall_pulses", pc[3][1], 2);
      chk("t6_other_ch",    pc[2][0] + pc[3][0], 0);
      hs[2] = 0;
      hs[3] = 0;
      ready[2] = 1'b1;
      ready[3] = 1'b1;
      ticks(8);
      chk("t6_rise_grants", hs[2], 3);
      chk("t6_fall_grants", hs[3], 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
